// File: rtl/load_store_unit_pkg.sv
// Shared types, constants and access-geometry helpers for the load/store unit.
package Types;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } AccessSize;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    RESP
  } LsuState;

  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // True when the access runs past the end of its 4-byte word.
  function automatic logic access_crosses(input logic [1:0] size, input logic [1:0] offset);
    return ({1'b0, offset} + access_bytes(size)) > 3'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/DataMemoryBus.sv
// Word-addressed data memory port; read data is combinational from addr.
interface DataMemoryBus;
  logic [31:0] addr;
  logic        wrEnable;
  logic [3:0]  wrMask;
  logic [31:0] wrData;
  logic [31:0] rdData;

  modport master (output addr, wrEnable, wrMask, wrData, input rdData);
  modport slave  (input addr, wrEnable, wrMask, wrData, output rdData);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/data placement across two beats and
// load extraction with sign or zero extension.
module lsu_align
  import Types::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [3:0]  o_mask_lo,
  output logic [3:0]  o_mask_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_load_data
);

  logic [5:0]  shamt;
  logic [7:0]  mask_base;
  logic [7:0]  mask_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rdata_shifted;

  assign shamt = {1'b0, i_offset, 3'b000};

  // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
  always_comb begin
    mask_base = 8'h0F;
    case (i_size)
      BYTE:    mask_base = 8'h01;
      HALF:    mask_base = 8'h03;
      default: mask_base = 8'h0F;
    endcase
  end

  // Bits shifted past lane 3 become the second beat.
  assign mask_wide     = mask_base << i_offset;
  assign wdata_wide    = {32'h0, i_wdata} << shamt;
  assign rdata_shifted = 32'({i_rdata_hi, i_rdata_lo} >> shamt);

  assign o_mask_lo  = mask_wide[3:0];
  assign o_mask_hi  = mask_wide[7:4];
  assign o_wdata_lo = wdata_wide[31:0];
  assign o_wdata_hi = wdata_wide[63:32];

  always_comb begin
    o_load_data = rdata_shifted;
    case (i_size)
      BYTE:    o_load_data = {{24{~i_unsigned & rdata_shifted[7]}},  rdata_shifted[7:0]};
      HALF:    o_load_data = {{16{~i_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: o_load_data = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: window and size checking, one or two bus beats, held response.
// Define LSU_MISALIGNED_EN to split word-crossing accesses instead of rejecting them.
module load_store_unit
  import Types::*;
#(
  parameter int unsigned BASE = 0,
  parameter int unsigned SIZE = 1024
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_write,
  input  logic [1:0]   i_req_size,
  input  logic         i_req_unsigned,
  input  logic [31:0]  i_req_addr,
  input  logic [31:0]  i_req_wdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [31:0]  o_rsp_rdata,
  output logic         o_rsp_error,
  DataMemoryBus.master bus
);

  LsuState     state_q;
  AccessSize   size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic        req_err;
  logic [32:0] req_end;
  logic [32:0] win_end;
  logic [31:0] word_addr;
  logic [31:0] rdata_lo;
  logic [3:0]  mask_lo, mask_hi;
  logic [31:0] wdata_lo, wdata_hi;
  logic [31:0] load_data;
  logic [31:0] rsp_rdata_d;

  // 33-bit sums so a window or access ending at 2^32 cannot wrap.
  assign win_end = 33'(BASE) + 33'(SIZE);
  assign req_end = {1'b0, i_req_addr} + 33'(access_bytes(i_req_size));

  always_comb begin
    req_err = (i_req_size == 2'b11) || (i_req_addr < 32'(BASE)) || (req_end > win_end);
`ifdef LSU_MISALIGNED_EN
    req_err = req_err;
`else
    req_err = req_err || access_crosses(i_req_size, i_req_addr[1:0]);
`endif
  end

  assign word_addr   = {addr_q[31:2], 2'b00};
  assign rdata_lo    = (state_q == SECOND) ? lo_q : bus.rdData;
  assign rsp_rdata_d = write_q ? 32'h0 : load_data;

  lsu_align u_align (
    .i_size      (size_q),
    .i_unsigned  (unsigned_q),
    .i_offset    (addr_q[1:0]),
    .i_wdata     (wdata_q),
    .i_rdata_lo  (rdata_lo),
    .i_rdata_hi  (bus.rdData),
    .o_mask_lo   (mask_lo),
    .o_mask_hi   (mask_hi),
    .o_wdata_lo  (wdata_lo),
    .o_wdata_hi  (wdata_hi),
    .o_load_data (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      size_q      <= BYTE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_req_valid) begin
          write_q    <= i_req_write;
          unsigned_q <= i_req_unsigned;
          addr_q     <= i_req_addr;
          wdata_q    <= i_req_wdata;
          if (req_err) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            size_q  <= AccessSize'(i_req_size);
            state_q <= FIRST;
          end
        end
        FIRST: begin
          lo_q <= bus.rdData;
`ifdef LSU_MISALIGNED_EN
          if (access_crosses(size_q, addr_q[1:0])) begin
            state_q <= SECOND;
          end else begin
            rsp_rdata_q <= rsp_rdata_d;
            state_q     <= RESP;
          end
`else
          rsp_rdata_q <= rsp_rdata_d;
          state_q     <= RESP;
`endif
        end
        SECOND: begin
          rsp_rdata_q <= rsp_rdata_d;
          state_q     <= RESP;
        end
        RESP: if (i_rsp_ready) begin
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.addr     = '0;
    bus.wrEnable = 1'b0;
    bus.wrMask   = '0;
    bus.wrData   = '0;
    case (state_q)
      FIRST: begin
        bus.addr     = word_addr;
        bus.wrEnable = write_q;
        bus.wrMask   = write_q ? mask_lo : 4'h0;
        bus.wrData   = write_q ? wdata_lo : 32'h0;
      end
      SECOND: begin
        bus.addr     = word_addr + 32'(WORD_BYTES);
        bus.wrEnable = write_q;
        bus.wrMask   = write_q ? mask_hi : 4'h0;
        bus.wrData   = write_q ? wdata_hi : 32'h0;
      end
      default: ;
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_error = rsp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a write-beat log.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  int passed = 0;
  int total  = 0;

  DataMemoryBus mem_bus ();

  load_store_unit #(.BASE(0), .SIZE(1024)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_error    (rsp_error),
    .bus            (mem_bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] beat_addr [16];
  logic [3:0]  beat_mask [16];
  logic [31:0] beat_data [16];
  int beat_cnt   = 0;
  int access_cnt = 0;

  assign mem_bus.rdData = mem[mem_bus.addr[9:2]];

  always @(posedge clk) begin
    if (mem_bus.addr != 32'h0 || mem_bus.wrEnable) access_cnt <= access_cnt + 1;
    if (mem_bus.wrEnable) begin
      if (beat_cnt < 16) begin
        beat_addr[beat_cnt] <= mem_bus.addr;
        beat_mask[beat_cnt] <= mem_bus.wrMask;
        beat_data[beat_cnt] <= mem_bus.wrData;
      end
      beat_cnt <= beat_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (mem_bus.wrMask[b]) mem[mem_bus.addr[9:2]][b*8 +: 8] <= mem_bus.wrData[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one request, returns cycles from the accept edge until o_rsp_valid.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  int lat, b0, a0;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h80FF1234;
    mem[255]          = 32'h5A5AA5A5;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    check("rst_bus_addr",  mem_bus.addr, 32'h0);
    check("rst_bus_wren",  32'(mem_bus.wrEnable), 32'h0);
    check("rst_bus_mask",  32'(mem_bus.wrMask), 32'h0);
    check("rst_bus_wdata", mem_bus.wrData, 32'h0);
    rst = 1'b0;

    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, lat);
    check("lb_signed_data", rsp_rdata, 32'hFFFFFFFF);
    check("lb_signed_err", 32'(rsp_error), 32'h0);
    check("lb_signed_lat", 32'(lat), 32'd2);
    ack();
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, lat);
    check("lbu_data", rsp_rdata, 32'h000000FF);
    ack();
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat);
    check("lh_signed_data", rsp_rdata, 32'hFFFF80FF);
    ack();
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat);
    check("lh_pos_data", rsp_rdata, 32'h00001234);
    ack();

    b0 = beat_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, lat);
    check("sb_beats", 32'(beat_cnt - b0), 32'd1);
    check("sb_addr",  beat_addr[b0], 32'h100);
    check("sb_mask",  32'(beat_mask[b0]), 32'h8);
    check("sb_wdata", beat_data[b0], 32'hAB000000);
    check("sb_lat",   32'(lat), 32'd2);
    check("sb_err",   32'(rsp_error), 32'h0);
    check("sb_rdata", rsp_rdata, 32'h0);
    ack();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat);
    check("lw_after_sb", rsp_rdata, 32'hABFF1234);
    ack();

    b0 = beat_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h11223344, lat);
`ifdef LSU_MISALIGNED_EN
    check("split_sw_beats", 32'(beat_cnt - b0), 32'd2);
    check("split_sw_addr0", beat_addr[b0], 32'h4);
    check("split_sw_mask0", 32'(beat_mask[b0]), 32'hC);
    check("split_sw_data0", beat_data[b0], 32'h33440000);
    check("split_sw_addr1", beat_addr[b0+1], 32'h8);
    check("split_sw_mask1", 32'(beat_mask[b0+1]), 32'h3);
    check("split_sw_data1", beat_data[b0+1], 32'h00001122);
    check("split_sw_lat",   32'(lat), 32'd3);
    check("split_sw_err",   32'(rsp_error), 32'h0);
    ack();
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat);
    check("split_lw_data", rsp_rdata, 32'h11223344);
    check("split_lw_lat",  32'(lat), 32'd3);
    ack();
`else
    check("cross_sw_beats", 32'(beat_cnt - b0), 32'd0);
    check("cross_sw_err",   32'(rsp_error), 32'h1);
    check("cross_sw_lat",   32'(lat), 32'd1);
    ack();
`endif

    a0 = access_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat);
    check("oob_err",    32'(rsp_error), 32'h1);
    check("oob_lat",    32'(lat), 32'd1);
    check("oob_no_bus", 32'(access_cnt - a0), 32'd0);
    ack();
    issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat);
    check("last_word_err",  32'(rsp_error), 32'h0);
    check("last_word_data", rsp_rdata, 32'h5A5AA5A5);
    ack();
    a0 = access_cnt;
    issue(1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, lat);
    check("straddle_err",    32'(rsp_error), 32'h1);
    check("straddle_no_bus", 32'(access_cnt - a0), 32'd0);
    ack();
    a0 = access_cnt;
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat);
    check("size11_err",    32'(rsp_error), 32'h1);
    check("size11_rdata",  rsp_rdata, 32'h0);
    check("size11_no_bus", 32'(access_cnt - a0), 32'd0);
    ack();

    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      check("hold_rsp_rdata", rsp_rdata, 32'hABFF1234);
      check("hold_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    ack();
    check("after_ack_ready", 32'(req_ready), 32'h1);

    // Reset mid-FIRST: abort before any write beat lands.
    b0 = beat_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef LSU_MISALIGNED_EN
    req_addr = 32'h6;
`else
    req_addr = 32'h10;
`endif
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("first_wren", 32'(mem_bus.wrEnable), 32'h1);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_beats",     32'(beat_cnt - b0), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_bus_wren",  32'(mem_bus.wrEnable), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BASE, default 0, meaning the lowest legal byte address; requests below it return o_rsp_error=1 with no bus access.
REQ-002 SHALL have parameter SIZE, default 1024, meaning the legal window in bytes; addresses at or beyond BASE+SIZE return o_rsp_error=1 with no bus access.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does: i_clock (in, 1, rising-edge clock) and i_reset (in, 1, async active-high reset).
REQ-004 i_req_valid  in  1  request present.
REQ-005 o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
REQ-006 i_req_write  in  1  1=store, 0=load.
REQ-007 i_req_size  in  2  00 byte, 01 half, 10 word; 11 illegal, returns o_rsp_error=1.
REQ-008 i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 i_req_addr  in  32  byte address.
REQ-010 i_req_wdata  in  32  store data, right-aligned.
REQ-011 o_rsp_valid  out  1  response present.
REQ-012 i_rsp_ready  in  1  consumer accepts response.
REQ-013 o_rsp_rdata  out  32  extended load data; 0 for stores.
REQ-014 o_rsp_error  out  1  illegal size, out of range, or misaligned access when splitting is compiled out.
REQ-015 bus  DataMemoryBus.master  --  memory port; addr, wrEnable, wrMask[3:0], wrData out; rdData in, combinational.

Function
REQ-016 FSM states: IDLE, FIRST, SECOND, RESP.
REQ-017 o_req_ready SHALL be 1 only in IDLE; on valid&ready the request is latched and the FSM goes to FIRST.
REQ-018 FIRST: bus.addr = word-aligned request address; stores assert wrEnable for exactly one cycle with mask/data shifted by addr[1:0]; loads capture rdData at the clock edge.
REQ-019 Next state from FIRST: SECOND if the access crosses a 4-byte boundary (half at offset 3; word at offset 1-3), else RESP.
REQ-020 SECOND: bus.addr = first address + 4; carries the remaining bytes; next state RESP.
REQ-021 RESP: o_rsp_valid=1 with stable rdata/error until i_rsp_ready=1; then go to IDLE.
REQ-022 Latency from accept edge to o_rsp_valid: 2 cycles for a single access, 3 for a split access, 1 for an errored request (errored requests skip FIRST).
REQ-023 Outside FIRST/SECOND: bus.wrEnable=0, wrMask=0, addr=0, wrData=0.
REQ-024 Store byte mask: 0001<<off; half: 0011<<off; word: 1111<<off, truncated to 4 bits per beat, with overflow bits applied in SECOND.
REQ-025 Load extension SHALL use bit 7 (byte) or bit 15 (half) when signed.
REQ-026 An address+size straddling BASE+SIZE SHALL error with no bus access.

Reset
REQ-027 i_reset SHALL force IDLE asynchronously, with o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_error=0, and all bus outputs 0.
REQ-028 Reset asserted during FIRST or SECOND SHALL abort the request: no further write beat is issued and no response is produced.

Configuration
REQ-029 Macro LSU_MISALIGNED_EN: when defined, boundary-crossing accesses split per REQ-019/020.
REQ-030 When LSU_MISALIGNED_EN is undefined, a crossing access SHALL return o_rsp_error=1 with no bus access, and SECOND is unreachable.

Structure
REQ-031 Package Types SHALL hold typedefs AccessSize (enum BYTE/HALF/WORD) and LsuState, plus constant WORD_BYTES=4.
REQ-032 Shifting, masking and extension SHALL live in combinational sub-module lsu_align; the FSM stays in load_store_unit.

Verification
REQ-033 Store byte at 0x103, data 0xAB -> one beat: addr 0x100, mask 1000, wrData 0xAB000000; rsp after 2 cycles, error=0.
REQ-034 Memory word 0x100 = 0x80FF1234; signed byte load at 0x102 -> rdata 0xFFFFFFFF; unsigned -> 0x000000FF.
REQ-035 With LSU_MISALIGNED_EN, word store at 0x6, data 0x11223344 -> beat 1: addr 0x4, mask 1100, data 0x33440000; beat 2: addr 0x8, mask 0011, data 0x00001122; rsp after 3 cycles.
REQ-036 Without LSU_MISALIGNED_EN, the same store -> no wrEnable, error=1, rsp after 1 cycle.
REQ-037 Load at 0x400 with SIZE=1024 -> error=1, no bus access; a valid request with size=11 -> error=1.
REQ-038 i_rsp_ready held 0 for 5 cycles -> o_rsp_valid and data stay stable and o_req_ready stays 0; reset pulsed in FIRST of a split store -> second beat never issued.
